// File: rtl/mvs_pkg.sv
// Shared constants and helpers for the multi-view splitter: legal view counts
// and the width function used to size column and address counters.
package mvs_pkg;

  localparam int N_VIEWS_MIN = 2;
  localparam int N_VIEWS_MAX = 4;

  // Bits needed to index n entries; never less than one bit.
  function automatic int col_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvs_line_buf.sv
// Simple dual-port line buffer with a registered read port.
// A write to the address being read in the same cycle is forwarded to the read data.
module mvs_line_buf
  import mvs_pkg::*;
#(
  parameter int DEPTH = 400,
  parameter int WIDTH = 8,
  localparam int AW = col_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wrEn_i,
  input  logic [AW-1:0]    wrAddr_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic             rdEn_i,
  input  logic [AW-1:0]    rdAddr_i,
  output logic [WIDTH-1:0] rdData_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdDataQ;

  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
    if (rdEn_i) begin
      if (wrEn_i && (wrAddr_i == rdAddr_i)) begin
        rdDataQ <= wrData_i;
      end else begin
        rdDataQ <= mem[rdAddr_i];
      end
    end
  end

  assign rdData_o = rdDataQ;

endmodule

// File: rtl/multi_view_splitter.sv
// Splits a line of N_VIEWS side-by-side views into co-located pixel words.
// Optional macro MVS_LINE_CHECK_EN adds a sticky line_err output for short/long lines.
module multi_view_splitter
  import mvs_pkg::*;
#(
  parameter int N_VIEWS  = 2,
  parameter int VIEW_W   = 400,
  parameter int PX_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         de_in,
  input  logic                         h_sync_in,
  input  logic                         v_sync_in,
  input  logic [PX_WIDTH-1:0]          pixel_in,
  output logic                         clk_out,
  output logic                         de_out,
  output logic                         h_sync_out,
  output logic                         v_sync_out,
`ifdef MVS_LINE_CHECK_EN
  output logic                         line_err,
`endif
  output logic [N_VIEWS*PX_WIDTH-1:0]  pixel_out
);

  localparam int TOTAL = N_VIEWS * VIEW_W;
  localparam int CW    = col_width(TOTAL);
  localparam int AW    = col_width(VIEW_W);
  localparam logic [CW-1:0] LAST_COL = CW'(TOTAL - 1);

  if ((N_VIEWS < N_VIEWS_MIN) || (N_VIEWS > N_VIEWS_MAX)) begin : g_bad_cfg
    $error("multi_view_splitter: N_VIEWS must be within 2..4");
  end

  logic [CW-1:0]       colQ, colD;
  logic                overQ, overD;
  logic                holdQ, holdD;
  logic                deOutQ;
  logic                hsQ, vsQ;
  logic [PX_WIDTH-1:0] lastPixQ;
  logic                pixValid;
  logic                rdEn;
  logic [N_VIEWS-2:0]  wrEn;
  logic [AW-1:0]       bufAddr;
  logic [PX_WIDTH-1:0] bufRd [N_VIEWS-1];
  int                  viewIdx;

  assign clk_out = clk;

  // overQ marks a completed line (extra pixels ignored); holdQ blocks a line cut by reset.
  always_comb begin
    pixValid = de_in && !overQ && !holdQ;
    viewIdx  = 0;
    for (int k = 1; k < N_VIEWS; k++) begin
      if (int'(colQ) >= k * VIEW_W) begin
        viewIdx = k;
      end
    end
    bufAddr = AW'(int'(colQ) - viewIdx * VIEW_W);
    rdEn    = pixValid && (viewIdx == N_VIEWS - 1);
    for (int v = 0; v < N_VIEWS - 1; v++) begin
      wrEn[v] = pixValid && (viewIdx == v);
    end
  end

  always_comb begin
    colD  = colQ;
    overD = overQ;
    holdD = holdQ;
    if (!de_in) begin
      colD  = '0;
      overD = 1'b0;
      holdD = 1'b0;
    end else if (pixValid) begin
      if (colQ == LAST_COL) begin
        overD = 1'b1;
      end else begin
        colD = colQ + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      colQ     <= '0;
      overQ    <= 1'b0;
      holdQ    <= 1'b1;
      deOutQ   <= 1'b0;
      hsQ      <= 1'b0;
      vsQ      <= 1'b0;
      lastPixQ <= '0;
    end else begin
      colQ     <= colD;
      overQ    <= overD;
      holdQ    <= holdD;
      deOutQ   <= rdEn;
      hsQ      <= h_sync_in;
      vsQ      <= v_sync_in;
      lastPixQ <= pixel_in;
    end
  end

  for (genvar v = 0; v < N_VIEWS - 1; v++) begin : g_buf
    mvs_line_buf #(
      .DEPTH (VIEW_W),
      .WIDTH (PX_WIDTH)
    ) u_buf (
      .clk      (clk),
      .wrEn_i   (wrEn[v]),
      .wrAddr_i (bufAddr),
      .wrData_i (pixel_in),
      .rdEn_i   (rdEn),
      .rdAddr_i (bufAddr),
      .rdData_o (bufRd[v])
    );
  end

  always_comb begin
    pixel_out = '0;
    if (deOutQ) begin
      for (int v = 0; v < N_VIEWS - 1; v++) begin
        pixel_out[v*PX_WIDTH +: PX_WIDTH] = bufRd[v];
      end
      pixel_out[(N_VIEWS-1)*PX_WIDTH +: PX_WIDTH] = lastPixQ;
    end
  end

  assign de_out     = deOutQ;
  assign h_sync_out = hsQ;
  assign v_sync_out = vsQ;

`ifdef MVS_LINE_CHECK_EN
  // vsQ is the previous v_sync_in, so it doubles as the rising-edge reference.
  logic lineErrQ;
  logic shortLine, longLine;

  assign shortLine = !de_in && (colQ != '0) && !overQ;
  assign longLine  = de_in && overQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      lineErrQ <= 1'b0;
    end else if (v_sync_in && !vsQ) begin
      lineErrQ <= 1'b0;
    end else if (shortLine || longLine) begin
      lineErrQ <= 1'b1;
    end
  end

  assign line_err = lineErrQ;
`endif

endmodule
